// File: rtl/pci_master.sv
// PCI bus master: single-data-phase memory read/write initiator with
// retry, master-abort and target-abort handling.
// Ports:
//   clk, rst         : clock, synchronous active-low reset
//   ad, cbe, par     : multiplexed address/data, command/byte enables, parity
//   frame, irdy      : master-driven control (active low)
//   trdy, stop, devsel : target-driven control (sampled only)
//   req / gnt        : arbitration request / grant (active low)
//   mst_*            : local request side (start, command fields, results)
module pci_master #(
  parameter int DEVSEL_TIMEOUT = 5,
  parameter int RETRY_LIMIT    = 8
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [31:0] ad,
  inout  wire  [3:0]  cbe,
  inout  wire         par,
  inout  wire         frame,
  inout  wire         irdy,
  inout  wire         trdy,
  inout  wire         stop,
  inout  wire         devsel,
  output logic        req,
  input  logic        gnt,
  input  logic        mst_start,
  input  logic        mst_iswrite,
  input  logic [31:0] mst_addr,
  input  logic [3:0]  mst_be,
  input  logic [31:0] mst_wdata,
  output logic [31:0] mst_rdata,
  output logic        mst_busy,
  output logic        mst_done,
  output logic [1:0]  mst_status
);

  localparam int TW = $clog2(DEVSEL_TIMEOUT + 1);
  localparam int RW = $clog2(RETRY_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ADDR,
    S_DATA,
    S_TAR
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0]   r_addr;
  logic [3:0]    r_be;
  logic [31:0]   r_wdata;
  logic          r_wr;
  logic [RW-1:0] r_retry;
  logic [TW-1:0] r_to;
  logic          r_dsel_seen;
  logic          r_final;
  logic [1:0]    r_status;
  logic [31:0]   r_rdata;
  logic          r_par;
  logic          r_par_oe;

  logic          w_accept;
  logic          w_ctl_oe;
  logic          w_ad_oe;
  logic [31:0]   w_ad_o;
  logic [3:0]    w_cbe_o;
  logic [3:0]    w_cmd;
  logic          w_ok;
  logic          w_retry;
  logic          w_tabort;
  logic          w_mabort;
  logic          w_rty_max;
  logic          w_exit;

  // Local request side
  assign mst_done   = (r_state == S_TAR) && r_final;
  assign mst_busy   = (r_state != S_IDLE) && !mst_done;
  assign mst_rdata  = r_rdata;
  assign mst_status = r_status;
  assign w_accept   = mst_start && !mst_busy;

  // Bus drive
  assign w_cmd    = r_wr ? 4'b0111 : 4'b0110;
  assign w_ctl_oe = (r_state == S_ADDR) ||
                    (r_state == S_DATA) ||
                    (r_state == S_TAR);
  assign w_ad_oe  = (r_state == S_ADDR) ||
                    ((r_state == S_DATA) && r_wr);
  assign w_ad_o   = (r_state == S_ADDR) ?
                    {r_addr[31:2], 2'b00} : r_wdata;
  assign w_cbe_o  = (r_state == S_ADDR) ? w_cmd : r_be;

  assign req   = !((r_state == S_REQ) ||
                   (r_state == S_ADDR));
  assign frame = w_ctl_oe ?
                 (r_state != S_ADDR) : 1'bz;
  assign irdy  = w_ctl_oe ?
                 (r_state != S_DATA) : 1'bz;
  assign cbe   = w_ctl_oe ? w_cbe_o : 4'bz;
  assign ad    = w_ad_oe ? w_ad_o : 32'bz;
  assign par   = r_par_oe ? r_par : 1'bz;

  // Data-phase termination, highest priority first
  assign w_ok      = !trdy && !irdy;
  assign w_retry   = !stop && trdy && !devsel;
  assign w_tabort  = !stop && devsel && r_dsel_seen;
  assign w_mabort  = !r_dsel_seen && devsel &&
                     (r_to == TW'(DEVSEL_TIMEOUT - 1));
  assign w_rty_max = (r_retry == RW'(RETRY_LIMIT - 1));
  assign w_exit    = w_ok || w_retry ||
                     w_tabort || w_mabort;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_REQ;
      end
      S_REQ: begin
        if (!gnt && frame && irdy)
          w_next = S_ADDR;
      end
      S_ADDR: w_next = S_DATA;
      S_DATA: begin
        if (w_exit) w_next = S_TAR;
      end
      S_TAR: begin
        // A non-final TAR is a retry: re-arbitrate
        if (!r_final || w_accept)
          w_next = S_REQ;
        else
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_wr        <= 1'b0;
      r_retry     <= '0;
      r_to        <= '0;
      r_dsel_seen <= 1'b0;
      r_final     <= 1'b0;
      r_status    <= 2'b00;
      r_rdata     <= '0;
      r_par       <= 1'b0;
      r_par_oe    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_par    <= ^{w_ad_o, w_cbe_o};
      r_par_oe <= w_ad_oe;

      if (w_accept) begin
        r_addr  <= mst_addr;
        r_be    <= mst_be;
        r_wdata <= mst_wdata;
        r_wr    <= mst_iswrite;
        r_retry <= '0;
      end

      if (r_state == S_ADDR) begin
        r_to        <= '0;
        r_dsel_seen <= 1'b0;
      end

      if (r_state == S_DATA) begin
        r_to <= r_to + 1'b1;
        if (!devsel) r_dsel_seen <= 1'b1;
        if (w_ok) begin
          r_final  <= 1'b1;
          r_status <= 2'b00;
          if (!r_wr) r_rdata <= ad;
        end else if (w_retry) begin
          r_retry <= r_retry + 1'b1;
          r_final <= w_rty_max;
          if (w_rty_max) r_status <= 2'b11;
        end else if (w_tabort) begin
          r_final  <= 1'b1;
          r_status <= 2'b10;
        end else if (w_mabort) begin
          r_final  <= 1'b1;
          r_status <= 2'b01;
        end
      end
    end
  end

endmodule

// File: tb/tb_pci_master.sv
// Testbench for pci_master: directed transactions against a small
// behavioural target, with a queue-based scoreboard monitor.
module tb_pci_master;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wire [31:0] ad;
  wire [3:0]  cbe;
  wire par, frame, irdy, trdy, stop, devsel;
  logic req;
  logic gnt_r = 1'b0;

  logic        mst_start = 1'b0;
  logic        mst_iswrite = 1'b0;
  logic [31:0] mst_addr = '0;
  logic [3:0]  mst_be = '0;
  logic [31:0] mst_wdata = '0;
  logic [31:0] mst_rdata;
  logic        mst_busy, mst_done;
  logic [1:0]  mst_status;

  pullup (frame);
  pullup (irdy);
  pullup (par);

  // Target-side drivers
  logic        t_trdy = 1'b1;
  logic        t_stop = 1'b1;
  logic        t_devsel = 1'b1;
  logic        t_ad_oe = 1'b0;
  logic [31:0] t_ad = '0;
  assign trdy   = t_trdy;
  assign stop   = t_stop;
  assign devsel = t_devsel;
  assign ad     = t_ad_oe ? t_ad : 32'bz;

  pci_master #(.DEVSEL_TIMEOUT(5), .RETRY_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .ad(ad), .cbe(cbe), .par(par),
    .frame(frame), .irdy(irdy), .trdy(trdy),
    .stop(stop), .devsel(devsel),
    .req(req), .gnt(gnt_r),
    .mst_start(mst_start), .mst_iswrite(mst_iswrite),
    .mst_addr(mst_addr), .mst_be(mst_be),
    .mst_wdata(mst_wdata), .mst_rdata(mst_rdata),
    .mst_busy(mst_busy), .mst_done(mst_done),
    .mst_status(mst_status)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(string nm,
                     logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  cmd;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  status;
    logic [31:0] rdata;
    int          naddr;
    int          ndata;
  } exp_t;

  exp_t q[$];

  // Target behaviour knobs
  int          t_lat = 2;
  int          t_rty_left = 0;
  logic        t_always_rty = 1'b0;
  logic        t_none = 1'b0;
  logic        t_tabort = 1'b0;
  logic [31:0] t_rdval = '0;

  int   t_cnt = 0;
  logic t_active = 1'b0;
  logic t_rd = 1'b0;
  logic t_rty = 1'b0;

  always @(negedge clk) begin
    if (frame === 1'b0) begin
      t_active = 1'b1;
      t_cnt    = 0;
      t_rd     = (cbe == 4'b0110);
      t_rty    = t_always_rty || (t_rty_left > 0);
      if (t_rty_left > 0) t_rty_left--;
    end else if (t_active && irdy) begin
      t_trdy   = 1'b1;
      t_stop   = 1'b1;
      t_devsel = 1'b1;
      t_ad_oe  = 1'b0;
      t_active = 1'b0;
    end else if (t_active) begin
      t_cnt++;
      if (t_tabort) begin
        if (t_cnt == 1) t_devsel = 1'b0;
        else if (t_cnt == 2) begin
          t_devsel = 1'b1;
          t_stop   = 1'b0;
        end
      end else if (!t_none && t_cnt == t_lat) begin
        t_devsel = 1'b0;
        if (t_rty) t_stop = 1'b0;
        else begin
          t_trdy = 1'b0;
          if (t_rd) begin
            t_ad    = t_rdval;
            t_ad_oe = 1'b1;
          end
        end
      end
    end
  end

  // Scoreboard monitor
  logic       m_par_pend = 1'b0;
  logic       m_par_exp = 1'b0;
  int         m_naddr = 0;
  int         m_ndata = 0;

  always @(negedge clk) begin
    if (!rst) begin
      m_par_pend = 1'b0;
      m_naddr    = 0;
      m_ndata    = 0;
    end else begin
      if (m_par_pend) chk("par", 32'(par), 32'(m_par_exp));
      m_par_pend = 1'b0;
      if (q.size() > 0) begin
        if (frame === 1'b0) begin
          chk("addr", ad, q[0].addr);
          chk("cmd", 32'(cbe), 32'(q[0].cmd));
          m_naddr++;
          m_par_pend = 1'b1;
          m_par_exp  = ^{q[0].addr, q[0].cmd};
        end else if (irdy === 1'b0) begin
          chk("be", 32'(cbe), 32'(q[0].be));
          if (q[0].wr) begin
            chk("wdata", ad, q[0].wdata);
            m_par_pend = 1'b1;
            m_par_exp  = ^{q[0].wdata, q[0].be};
          end
          m_ndata++;
        end
        if (mst_done) begin
          chk("status", 32'(mst_status), 32'(q[0].status));
          chk("rdata", mst_rdata, q[0].rdata);
          chk("naddr", m_naddr, q[0].naddr);
          if (q[0].ndata >= 0)
            chk("ndata", m_ndata, q[0].ndata);
          chk("busy_at_done", 32'(mst_busy), 0);
          void'(q.pop_front());
          m_naddr = 0;
          m_ndata = 0;
        end
      end else if (mst_done) begin
        chk("spurious_done", 32'(mst_done), 0);
      end
    end
  end

  task automatic issue(logic wr, logic [31:0] a,
                       logic [3:0] be, logic [31:0] wd,
                       logic [31:0] bus_a,
                       logic [1:0] st, logic [31:0] rd,
                       int na, int nd);
    exp_t e;
    @(negedge clk);
    mst_start   = 1'b1;
    mst_iswrite = wr;
    mst_addr    = a;
    mst_be      = be;
    mst_wdata   = wd;
    e.wr     = wr;
    e.addr   = bus_a;
    e.cmd    = wr ? 4'b0111 : 4'b0110;
    e.be     = be;
    e.wdata  = wd;
    e.status = st;
    e.rdata  = rd;
    e.naddr  = na;
    e.ndata  = nd;
    q.push_back(e);
    @(negedge clk);
    mst_start = 1'b0;
  endtask

  task automatic wait_done(int lim);
    int i = 0;
    while (q.size() > 0 && i < lim) begin
      @(negedge clk);
      i++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d pending after %0d clocks",
               q.size(), lim);
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(mst_busy), 0);
    chk("rst_done", 32'(mst_done), 0);
    chk("rst_status", 32'(mst_status), 0);
    chk("rst_rdata", mst_rdata, 0);
    chk("rst_req", 32'(req), 1);
    chk("rst_frame", 32'(frame), 1);
    chk("rst_irdy", 32'(irdy), 1);
    rst = 1'b1;
    @(negedge clk);

    // Write, target responds 2 clocks after ADDR
    t_lat = 2;
    issue(1'b1, 32'h1000_0004, 4'b0000,
          32'hDEAD_BEEF, 32'h1000_0004,
          2'b00, 32'h0, 1, 2);
    wait_done(50);

    // Read; a second start while busy is ignored
    t_rdval = 32'h1234_5678;
    issue(1'b0, 32'h2000_0000, 4'b1100,
          32'h0, 32'h2000_0000,
          2'b00, 32'h1234_5678, 1, 2);
    @(negedge clk);
    chk("busy_mid", 32'(mst_busy), 1);
    mst_start   = 1'b1;
    mst_iswrite = 1'b1;
    mst_addr    = 32'hBAD0_0000;
    @(negedge clk);
    mst_start = 1'b0;
    wait_done(50);

    // Master abort: nobody answers
    t_none = 1'b1;
    issue(1'b0, 32'h2000_0010, 4'b0000,
          32'h0, 32'h2000_0010,
          2'b01, 32'h1234_5678, 1, 5);
    wait_done(50);
    t_none = 1'b0;

    // Three retries then success; low address bits forced to 00
    t_rty_left = 3;
    issue(1'b1, 32'h3000_000B, 4'b0101,
          32'hA5A5_0F0F, 32'h3000_0008,
          2'b00, 32'h1234_5678, 4, 8);
    wait_done(200);

    // Endless retry hits the limit
    t_always_rty = 1'b1;
    issue(1'b0, 32'h4000_0000, 4'b0000,
          32'h0, 32'h4000_0000,
          2'b11, 32'h1234_5678, 8, 16);
    wait_done(400);
    t_always_rty = 1'b0;

    // Target abort
    t_tabort = 1'b1;
    issue(1'b1, 32'h5000_0000, 4'b0000,
          32'h0, 32'h5000_0000,
          2'b10, 32'h1234_5678, 1, 2);
    wait_done(50);
    t_tabort = 1'b0;

    // Reset in the data phase
    t_none = 1'b1;
    issue(1'b0, 32'h7000_0000, 4'b0000,
          32'h0, 32'h7000_0000,
          2'b01, 32'h1234_5678, 1, 5);
    n = 0;
    while (irdy !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("reached_data", 32'(irdy), 0);
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    chk("rr_frame", 32'(frame), 1);
    chk("rr_irdy", 32'(irdy), 1);
    chk("rr_par", 32'(par), 1);
    chk("rr_req", 32'(req), 1);
    chk("rr_busy", 32'(mst_busy), 0);
    chk("rr_done", 32'(mst_done), 0);
    chk("rr_rdata", mst_rdata, 0);
    chk("rr_status", 32'(mst_status), 0);
    rst = 1'b1;
    t_none = 1'b0;
    repeat (4) @(negedge clk);
    chk("rr_busy_after", 32'(mst_busy), 0);

    // Grant withheld 10 clocks
    gnt_r = 1'b1;
    t_lat = 1;
    issue(1'b1, 32'h6000_0000, 4'b0011,
          32'h1234_0000, 32'h6000_0000,
          2'b00, 32'h0, 1, 1);
    for (int i = 0; i < 10; i++) begin
      chk("nognt_req", 32'(req), 0);
      chk("nognt_frame", 32'(frame), 1);
      if (i < 9) @(negedge clk);
    end
    gnt_r = 1'b0;
    wait_done(50);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/pci_master.md
PCI_MASTER -- requirements
Module: pci_master

Interface
REQ-001 Parameters SHALL be: DEVSEL_TIMEOUT, default 5, clocks after the address phase before master abort; RETRY_LIMIT, default 8, maximum target retries per request.
REQ-002 Ports SHALL be (name  direction  width  meaning): clk  in  1  PCI clock, all logic on rising edge; rst  in  1  synchronous active-low reset.
REQ-003 ad  inout  32  address/data; cbe  inout  4  command/byte enables (active low); par  inout  1  even parity over ad+cbe.
REQ-004 frame, irdy, trdy, stop, devsel  inout  1 each  PCI control signals, active low; req  out  1  bus request, active low; gnt  in  1  bus grant, active low.
REQ-005 mst_start  in  1  one-cycle request pulse; mst_iswrite  in  1  1 = memory write (cmd 0111), 0 = memory read (cmd 0110); mst_addr  in  32  byte address, bits [1:0] forced to 00 on the bus.
REQ-006 mst_be  in  4  active-low byte enables; mst_wdata  in  32  write data; mst_rdata  out  32  read data; mst_busy  out  1  transaction in progress; mst_done  out  1  one-cycle completion pulse; mst_status  out  2  00 ok, 01 master abort, 10 target abort, 11 retry limit.
REQ-007 Clock and reset: one clock; reset is synchronous and active-low; ports named clk and rst.

Function
REQ-008 The block SHALL perform single-data-phase memory transactions only; a mst_start while mst_busy=1 SHALL be ignored.
REQ-009 On an accepted mst_start, the block SHALL capture addr/be/wdata/iswrite, set mst_busy=1, and go IDLE->REQ.
REQ-010 REQ: drive req=0; when gnt=0 AND frame=1 AND irdy=1 are sampled, go to ADDR.
REQ-011 ADDR (1 clock): drive frame=0, ad=captured address, cbe=command; go to DATA.
REQ-012 DATA: drive frame=1, irdy=0, cbe=captured be; on writes drive ad=wdata; on reads release ad (turnaround); deassert req on entry to DATA.
REQ-013 par SHALL be driven the clock after each clock in which the master drives ad (address phase, and every write data clock), with value = XOR of the previous clock's ad and cbe; par SHALL be released otherwise.
REQ-014 DATA exit on sampled trdy=0 and irdy=0: read latches ad into mst_rdata; status 00; go to TAR (this applies even if stop=0, a disconnect with data).
REQ-015 DATA exit on stop=0, trdy=1, devsel=0 (retry): increment retry counter; if it reaches RETRY_LIMIT, status 11 -> TAR; else go to TAR then REQ (re-arbitrate, same captured fields).
REQ-016 DATA exit on stop=0, devsel=1 after devsel was previously sampled 0 (target abort): status 10 -> TAR.
REQ-017 Master abort: devsel never sampled 0 during DEVSEL_TIMEOUT clocks counted from the clock after ADDR -> status 01 -> TAR; this SHALL take priority only when no trdy/stop exit applies.
REQ-018 TAR (1 clock): drive irdy=1 and frame=1 (frame, irdy, cbe, ad released at end); on final exits pulse mst_done=1 and clear mst_busy in the same clock, then IDLE.
REQ-019 The block SHALL never drive frame, irdy, cbe, or ad outside ADDR/DATA/TAR, and never drive trdy, stop, or devsel.
REQ-020 mst_rdata SHALL hold its value until the next successful read; mst_status SHALL hold until the next mst_done.

Reset
REQ-021 While rst=0 at a clock edge: state=IDLE, req=1, all inout pins released (Z), mst_busy=0, mst_done=0, mst_rdata=0, mst_status=00, retry and timeout counters=0.
REQ-022 Reset mid-transaction SHALL abandon it with no mst_done pulse; the bus SHALL be released the clock after reset is sampled.

Verification
REQ-023 Write addr 0x1000_0004, data 0xDEADBEEF, be 0000, gnt granted immediately, target trdy/devsel 2 clocks after ADDR -> cbe=0111 then 0000 on the bus, correct par each following clock, mst_done with status 00.
REQ-024 Read addr 0x2000_0000, target returns 0x12345678 -> mst_rdata=0x12345678, status 00, ad released during DATA.
REQ-025 No target responds -> irdy held for 5 clocks, then TAR, status 01.
REQ-026 Target retries 3 times then completes -> 4 ADDR phases observed, status 00; with target always retrying -> 8 ADDR phases, status 11.
REQ-027 devsel=0 for one clock, then stop=0 with devsel=1 -> status 10.
REQ-028 rst=0 asserted during DATA -> all pins Z next clock, mst_busy=0, no mst_done; gnt withheld 10 clocks -> req held 0, no ADDR.
